// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register pending-write scoreboard.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD-1:0]        i_rd_en,
  input  logic [NRD*ADDR_W-1:0] i_rd_idx,
  input  logic [NWR-1:0]        i_wr_en,
  input  logic [NWR*ADDR_W-1:0] i_wr_idx,
  input  logic [NWR*WIDTH-1:0]  i_wr_data,
  input  logic                  i_rsv_en,
  input  logic [ADDR_W-1:0]     i_rsv_idx,
  output logic [NRD*WIDTH-1:0]  o_rd_data,
  output logic [NRD-1:0]        o_rd_valid,
  output logic [NRD-1:0]        o_rd_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be in 1..4");
  end
  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("regfile_mp: NWR must be in 1..2");
  end
  if (WIDTH < 1 || ADDR_W < 1) begin : g_bad_size
    $error("regfile_mp: WIDTH and ADDR_W must be positive");
  end

  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [WIDTH-1:0]  r_rd_word [NRD];
  logic [NRD-1:0]    r_rd_valid;
  logic [NRD-1:0]    r_rd_busy;

  logic [ADDR_W-1:0] w_ridx  [NRD];
  logic [ADDR_W-1:0] w_widx  [NWR];
  logic [WIDTH-1:0]  w_wdata [NWR];
  logic [WIDTH-1:0]  w_rd_word [NRD];
  logic [NRD-1:0]    w_rd_busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd_unpack
    assign w_ridx[p] = i_rd_idx[p*ADDR_W +: ADDR_W];
    assign o_rd_data[p*WIDTH +: WIDTH] = r_rd_word[p];
  end

  for (genvar q = 0; q < NWR; q++) begin : g_wr_unpack
    assign w_widx[q]  = i_wr_idx[q*ADDR_W +: ADDR_W];
    assign w_wdata[q] = i_wr_data[q*WIDTH +: WIDTH];
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_busy  = r_rd_busy;

  // Read lookup; with forwarding, the highest-numbered matching write port wins.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      w_rd_word[p] = r_regs[w_ridx[p]];
      w_rd_busy[p] = r_pend[w_ridx[p]];
`ifdef REGFILE_MP_BYPASS_EN
      for (int q = 0; q < NWR; q++) begin
        if (i_wr_en[q] && (w_widx[q] == w_ridx[p])) begin
          w_rd_word[p] = w_wdata[q];
          w_rd_busy[p] = 1'b0;
        end
      end
`endif
      if (w_ridx[p] == '0) begin
        w_rd_word[p] = '0;
        w_rd_busy[p] = 1'b0;
      end
    end
  end

  // Later write ports and then the reserve are scheduled last so they take priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      for (int p = 0; p < NRD; p++) begin
        r_rd_word[p] <= '0;
      end
      r_pend     <= '0;
      r_rd_valid <= '0;
      r_rd_busy  <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        r_rd_valid[p] <= i_rd_en[p];
        if (i_rd_en[p]) begin
          r_rd_word[p] <= w_rd_word[p];
          r_rd_busy[p] <= w_rd_busy[p];
        end
      end
      for (int q = 0; q < NWR; q++) begin
        if (i_wr_en[q] && (w_widx[q] != '0)) begin
          r_regs[w_widx[q]] <= w_wdata[q];
          r_pend[w_widx[q]] <= 1'b0;
        end
      end
      if (i_rsv_en && (i_rsv_idx != '0)) begin
        r_pend[i_rsv_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a reference model checked every cycle
// plus literal expectations for the directed scenarios.
module tb_regfile_mp;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;
  localparam int NWR    = 2;
  localparam int DEPTH  = 32;

  logic                  clk;
  logic                  reset;
  logic [NRD-1:0]        rdEn;
  logic [NRD*ADDR_W-1:0] rdIdx;
  logic [NWR-1:0]        wrEn;
  logic [NWR*ADDR_W-1:0] wrIdx;
  logic [NWR*WIDTH-1:0]  wrData;
  logic                  rsvEn;
  logic [ADDR_W-1:0]     rsvIdx;
  logic [NRD*WIDTH-1:0]  rdData;
  logic [NRD-1:0]        rdValid;
  logic [NRD-1:0]        rdBusy;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .NRD(NRD), .NWR(NWR)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rd_en    (rdEn),
    .i_rd_idx   (rdIdx),
    .i_wr_en    (wrEn),
    .i_wr_idx   (wrIdx),
    .i_wr_data  (wrData),
    .i_rsv_en   (rsvEn),
    .i_rsv_idx  (rsvIdx),
    .o_rd_data  (rdData),
    .o_rd_valid (rdValid),
    .o_rd_busy  (rdBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents, pending bits and expected port outputs.
  logic [WIDTH-1:0] modelRegs [DEPTH];
  logic             modelPend [DEPTH];
  logic [WIDTH-1:0] expData   [NRD];
  logic             expValid  [NRD];
  logic             expBusy   [NRD];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        modelRegs[i] = '0;
        modelPend[i] = 1'b0;
      end
      for (int p = 0; p < NRD; p++) begin
        expData[p]  = '0;
        expValid[p] = 1'b0;
        expBusy[p]  = 1'b0;
      end
    end else begin
      for (int p = 0; p < NRD; p++) begin
        int idx;
        idx = int'(rdIdx[p*ADDR_W +: ADDR_W]);
        expValid[p] = rdEn[p];
        if (rdEn[p]) begin
          expData[p] = modelRegs[idx];
          expBusy[p] = modelPend[idx];
`ifdef REGFILE_MP_BYPASS_EN
          for (int q = NWR - 1; q >= 0; q--) begin
            if (wrEn[q] && int'(wrIdx[q*ADDR_W +: ADDR_W]) == idx) begin
              expData[p] = wrData[q*WIDTH +: WIDTH];
              expBusy[p] = 1'b0;
              break;
            end
          end
`endif
          if (idx == 0) begin
            expData[p] = '0;
            expBusy[p] = 1'b0;
          end
        end
      end
      for (int q = 0; q < NWR; q++) begin
        int widx;
        widx = int'(wrIdx[q*ADDR_W +: ADDR_W]);
        if (wrEn[q] && widx != 0) begin
          modelRegs[widx] = wrData[q*WIDTH +: WIDTH];
          modelPend[widx] = 1'b0;
        end
      end
      if (rsvEn && rsvIdx != 0) modelPend[int'(rsvIdx)] = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, 1 time unit after the falling edge, compare the DUT to the model.
  always @(negedge clk) begin
    #1;
    for (int p = 0; p < NRD; p++) begin
      checkOutput($sformatf("model_valid[%0d]", p), WIDTH'(rdValid[p]), WIDTH'(expValid[p]));
      checkOutput($sformatf("model_data[%0d]", p), rdData[p*WIDTH +: WIDTH], expData[p]);
      checkOutput($sformatf("model_busy[%0d]", p), WIDTH'(rdBusy[p]), WIDTH'(expBusy[p]));
    end
  end

  task automatic idleInputs();
    rdEn = '0; rdIdx = '0; wrEn = '0; wrIdx = '0; wrData = '0;
    rsvEn = 1'b0; rsvIdx = '0;
  endtask

  task automatic setRead(input int p, input int idx);
    rdEn[p] = 1'b1;
    rdIdx[p*ADDR_W +: ADDR_W] = ADDR_W'(idx);
  endtask

  task automatic setWrite(input int q, input int idx, input logic [WIDTH-1:0] data);
    wrEn[q] = 1'b1;
    wrIdx[q*ADDR_W +: ADDR_W] = ADDR_W'(idx);
    wrData[q*WIDTH +: WIDTH] = data;
  endtask

  // Let the current inputs be sampled by one rising edge, then clear them.
  task automatic applyStimulus();
    @(negedge clk);
    #2;
    idleInputs();
  endtask

  function automatic logic [WIDTH-1:0] portData(input int p);
    return rdData[p*WIDTH +: WIDTH];
  endfunction

  initial begin
    idleInputs();
    reset = 1'b1;
    #1;
    checkOutput("reset_valid", WIDTH'(rdValid), '0);
    checkOutput("reset_data0", portData(0), '0);
    // Requests while reset is held must be ignored.
    setWrite(0, 6, 32'h1234);
    setRead(0, 6);
    applyStimulus();
    applyStimulus();
    reset = 1'b0;

    // Read every index on both ports straight out of reset.
    for (int i = 0; i < DEPTH; i++) begin
      setRead(0, i);
      setRead(1, DEPTH - 1 - i);
      applyStimulus();
      checkOutput("rst_scan_valid", WIDTH'(rdValid), 32'h3);
      checkOutput("rst_scan_data0", portData(0), '0);
      checkOutput("rst_scan_busy", WIDTH'(rdBusy), '0);
    end

    setWrite(0, 5, 32'hDEADBEEF);
    applyStimulus();
    setRead(0, 5);
    setRead(1, 5);
    applyStimulus();
    checkOutput("wr_rd_valid", WIDTH'(rdValid), 32'h3);
    checkOutput("wr_rd_port0", portData(0), 32'hDEADBEEF);
    checkOutput("wr_rd_port1", portData(1), 32'hDEADBEEF);

    // Idle cycle: valid drops, data holds.
    applyStimulus();
    checkOutput("hold_valid", WIDTH'(rdValid), '0);
    checkOutput("hold_data1", portData(1), 32'hDEADBEEF);

    setWrite(0, 7, 32'h1);
    setWrite(1, 7, 32'h2);
    applyStimulus();
    setRead(0, 7);
    applyStimulus();
    checkOutput("collision", portData(0), 32'h2);

    rsvEn = 1'b1; rsvIdx = 5'd3;
    applyStimulus();
    setRead(0, 3);
    applyStimulus();
    checkOutput("sb_busy", WIDTH'(rdBusy[0]), 32'h1);
    setWrite(0, 3, 32'h55);
    applyStimulus();
    setRead(0, 3);
    applyStimulus();
    checkOutput("sb_clear_busy", WIDTH'(rdBusy[0]), '0);
    checkOutput("sb_clear_data", portData(0), 32'h55);

    // Reserve and write together: data commits, bit stays set.
    rsvEn = 1'b1; rsvIdx = 5'd4;
    setWrite(1, 4, 32'h44);
    applyStimulus();
    setRead(1, 4);
    applyStimulus();
    checkOutput("rsv_wr_data", portData(1), 32'h44);
    checkOutput("rsv_wr_busy", WIDTH'(rdBusy[1]), 32'h1);

    setWrite(0, 9, 32'h1111);
    applyStimulus();
    rsvEn = 1'b1; rsvIdx = 5'd9;
    applyStimulus();
    setRead(0, 9);
    setWrite(0, 9, 32'hA5A5);
    applyStimulus();
`ifdef REGFILE_MP_BYPASS_EN
    checkOutput("bypass_data", portData(0), 32'hA5A5);
    checkOutput("bypass_busy", WIDTH'(rdBusy[0]), '0);
`else
    checkOutput("bypass_data", portData(0), 32'h1111);
    checkOutput("bypass_busy", WIDTH'(rdBusy[0]), 32'h1);
`endif
    setRead(0, 9);
    applyStimulus();
    checkOutput("after_bypass", portData(0), 32'hA5A5);
    checkOutput("after_bypass_busy", WIDTH'(rdBusy[0]), '0);

    setWrite(0, 0, 32'hFFFF);
    rsvEn = 1'b1; rsvIdx = 5'd0;
    applyStimulus();
    setRead(0, 0);
    setRead(1, 0);
    applyStimulus();
    checkOutput("reg0_data", portData(0), '0);
    checkOutput("reg0_busy", WIDTH'(rdBusy), '0);

    // Short pseudo-random burst, checked only by the model.
    for (int n = 0; n < 200; n++) begin
      rdEn = NRD'($urandom_range(0, 3));
      rdIdx = (NRD*ADDR_W)'($urandom);
      wrEn = NWR'($urandom_range(0, 3));
      wrIdx = (NWR*ADDR_W)'($urandom_range(0, 7));
      wrData = {$urandom, $urandom};
      rsvEn = 1'($urandom_range(0, 1));
      rsvIdx = ADDR_W'($urandom_range(0, 7));
      @(negedge clk);
      #2;
    end
    idleInputs();

    // Reset in the middle of an outstanding read.
    setRead(0, 5);
    setRead(1, 7);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_valid", WIDTH'(rdValid), '0);
    checkOutput("midrst_data", portData(1), '0);
    idleInputs();
    applyStimulus();
    reset = 1'b0;
    setRead(0, 5);
    applyStimulus();
    checkOutput("post_rst_valid", WIDTH'(rdValid[0]), 32'h1);
    checkOutput("post_rst_data", portData(0), '0);

    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter WIDTH, default 32: data width of each register, in bits.
REQ-002 Parameter ADDR_W, default 5: index width; the file holds 2**ADDR_W registers.
REQ-003 Parameter NRD, default 2: number of read ports, range 1..4.
REQ-004 Parameter NWR, default 2: number of write ports, range 1..2.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 rd_en  in  NRD  per-port read request.
REQ-008 rd_idx  in  NRD*ADDR_W  read indices, port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 wr_en  in  NWR  per-port write request.
REQ-010 wr_idx  in  NWR*ADDR_W  write indices, packed as rd_idx.
REQ-011 wr_data  in  NWR*WIDTH  write data, port q at bits [q*WIDTH +: WIDTH].
REQ-012 rsv_en  in  1  scoreboard reserve request.
REQ-013 rsv_idx  in  ADDR_W  index to mark pending.
REQ-014 rd_data  out  NRD*WIDTH  registered read data, packed as wr_data.
REQ-015 rd_valid  out  NRD  rd_data for port p is valid this cycle.
REQ-016 rd_busy  out  NRD  read index had a pending write when sampled.

Function
REQ-017 Read latency SHALL be exactly 1 cycle: request at edge N, and rd_data, rd_valid and rd_busy update at edge N+1.
REQ-018 When rd_en[p]=0, rd_valid[p] SHALL be 0 on the next edge, and rd_data and rd_busy for port p SHALL hold their previous values.
REQ-019 Register 0 SHALL always read 0 and SHALL never be reported busy; writes and reserves to index 0 SHALL be ignored.
REQ-020 Writes SHALL commit on the rising edge when wr_en[q]=1 and wr_idx is nonzero.
REQ-021 When both write ports target the same index in the same cycle, port 1 SHALL win.
REQ-022 The scoreboard SHALL hold one pending bit per register; rsv_en SHALL set the bit for rsv_idx.
REQ-023 A committed write SHALL clear the pending bit for its index.
REQ-024 When a reserve and a write target the same index in the same cycle, the pending bit SHALL end set and the write data SHALL still commit.
REQ-025 rd_busy[p] SHALL reflect the pending bit before the edge's updates are applied.
REQ-026 All read ports SHALL be independent; any number of ports MAY read the same index in one cycle.
REQ-027 Out-of-range parameter values SHALL produce an elaboration-time error.

Reset
REQ-028 Reset assertion SHALL immediately clear all registers, all pending bits, rd_data, rd_valid and rd_busy to 0, without waiting for a clock edge.
REQ-029 While reset is high, writes, reserves and reads SHALL be ignored.
REQ-030 A request presented at the first edge after reset deassertion SHALL be serviced normally.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight read result; rd_valid SHALL be 0 after reset.

Configuration
REQ-032 Macro REGFILE_MP_BYPASS_EN SHALL select write-to-read forwarding.
REQ-033 With REGFILE_MP_BYPASS_EN defined, a read and a write to the same nonzero index in the same cycle SHALL return the new write data, using the winner per REQ-021.
REQ-034 With REGFILE_MP_BYPASS_EN defined, that forwarded read SHALL report rd_busy=0 when the write clears the pending bit.
REQ-035 With REGFILE_MP_BYPASS_EN undefined, that read SHALL return the pre-write value and the pre-edge busy state.

Verification
REQ-036 Reset scenario: drive reset, then read every index on all ports -> rd_data=0, rd_busy=0, and rd_valid=1 one cycle after each request.
REQ-037 Write/read scenario: write index 5 = 0xDEADBEEF on port 0, then read index 5 next cycle on ports 0 and 1 -> both return 0xDEADBEEF with 1-cycle latency.
REQ-038 Write-collision scenario: port 0 writes index 7 = 0x1 and port 1 writes index 7 = 0x2 in the same cycle -> later read of index 7 returns 0x2.
REQ-039 Scoreboard scenario: reserve index 3, read index 3 -> rd_busy=1; then write index 3 = 0x55 and read again next cycle -> rd_busy=0 and data 0x55.
REQ-040 Bypass scenario: read and write index 9 = 0xA5A5 in the same cycle -> data 0xA5A5 with the macro defined, the old value without it.
REQ-041 Register-0 scenario: write index 0 = 0xFFFF and reserve index 0, then read index 0 -> data 0 and rd_busy=0.
